down_timer: RTL and testbench

Programmable down-counting timer. It is the counterpart to the free-running up counter: software or an FSM loads a terminal count, and the block counts down to zero and signals expiry. It supports one-shot and periodic (auto-reload) modes, plus pause/resume and synchronous clear. It sits beside the up counter in peripheral/control logic as the timeout and periodic-tick source.

---
 rtl/timer_pkg.sv | 7 +
 rtl/timer_prescaler.sv | 44 ++++
 rtl/down_timer.sv | 102 ++++++++++
 tb/tb_down_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default widths for the down-counting timer.
package timer_pkg;
  localparam int TMR_WIDTH_DEF       = 16;
  localparam int TMR_PRESC_WIDTH_DEF = 8;

  typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_PAUSE} timer_state_e;
endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: tick_o on every (limit+1)-th enabled cycle. The limit is
// re-sampled from presc_i on clear and at each wrap.
module timer_prescaler #(
  parameter int PRESC_WIDTH = timer_pkg::TMR_PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  output logic                   tick_o
);
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESC_WIDTH-1:0] lim_q, lim_d;

  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      lim_d = presc_i;
    end else if (en_i) begin
      if (cnt_q == lim_q) begin
        tick_o = 1'b1;
        cnt_d  = '0;
        lim_d  = presc_i;
      end else begin
        cnt_d = cnt_q + PRESC_WIDTH'(1);
      end
    end
  end

  // With en_i low and clr_i low the counter simply holds (PAUSE).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end
endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer, one-shot or periodic, with pause/resume.
// Optional prescaler compiled in with DOWN_TIMER_PRESCALER_EN.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = TMR_WIDTH_DEF,
  parameter int PRESC_WIDTH = TMR_PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [WIDTH-1:0]       load_val_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   periodic_i,
`ifdef DOWN_TIMER_PRESCALER_EN
  input  logic [PRESC_WIDTH-1:0] presc_i,
`endif
  output logic [WIDTH-1:0]       count_o,
  output logic                   busy_o,
  output logic                   expired_o
);
  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;
  logic             tick;

  // Tick only on cycles where nothing of higher priority claims the edge.
  logic tick_en;
  assign tick_en = (state_q == TMR_RUN) && !clear_i && !load_i && !stop_i;

`ifdef DOWN_TIMER_PRESCALER_EN
  logic presc_clr;
  assign presc_clr = clear_i || load_i || (state_q == TMR_IDLE);

  timer_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (tick_en),
    .clr_i   (presc_clr),
    .presc_i (presc_i),
    .tick_o  (tick)
  );
`else
  localparam int unused_presc_width = PRESC_WIDTH;
  assign tick = tick_en;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
      state_d = TMR_IDLE;
    end else if (load_i) begin
      reload_d = load_val_i;
      count_d  = load_val_i;
      if (state_q == TMR_RUN && load_val_i == '0) state_d = TMR_IDLE;
    end else if (stop_i) begin
      if (state_q == TMR_RUN) state_d = TMR_PAUSE;
    end else if (start_i && state_q != TMR_RUN) begin
      if (state_q == TMR_PAUSE || count_q != '0) state_d = TMR_RUN;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        expired_d = 1'b1;
        if (periodic_i) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = TMR_IDLE;
        end
      end else begin
        // RUN at zero (load 0 while paused, then resumed): drop out quietly.
        state_d = TMR_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= TMR_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign busy_o    = (state_q != TMR_IDLE);
  assign expired_o = expired_q;
endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: random and directed stimulus against a
// cycle-level reference model; a negedge monitor pops and compares.
module tb_down_timer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         clear = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count_o;
  logic         busy_o, expired_o;
`ifdef DOWN_TIMER_PRESCALER_EN
  logic [7:0]   presc = 8'd0;
`endif

  always #5 clk = ~clk;

  down_timer dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .clear_i    (clear),
    .load_i     (load),
    .load_val_i (load_val),
    .start_i    (start),
    .stop_i     (stop),
    .periodic_i (periodic),
`ifdef DOWN_TIMER_PRESCALER_EN
    .presc_i    (presc),
`endif
    .count_o    (count_o),
    .busy_o     (busy_o),
    .expired_o  (expired_o)
  );

  typedef struct {
    int cnt;
    bit busy;
    bit exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_seen = 0;

  // Reference model: mode 0 idle, 1 counting, 2 paused.
  int m_mode = 0, m_cnt = 0, m_rel = 0, m_pc = 0, m_lim = 0;
  bit m_exp = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_rel = 0; m_pc = 0; m_lim = 0; m_exp = 0;
  endtask

  task automatic model_edge();
    bit tick;
    bit run_cycle;
    m_exp     = 0;
    run_cycle = (m_mode == 1) && !clear && !load && !stop;
    tick      = run_cycle;
`ifdef DOWN_TIMER_PRESCALER_EN
    tick = 0;
    if (clear || load || m_mode == 0) begin
      m_pc = 0; m_lim = int'(presc);
    end else if (run_cycle) begin
      if (m_pc == m_lim) begin
        tick = 1; m_pc = 0; m_lim = int'(presc);
      end else m_pc++;
    end
`endif
    if (clear) begin
      m_cnt = 0; m_mode = 0;
    end else if (load) begin
      m_rel = int'(load_val); m_cnt = int'(load_val);
      if (m_mode == 1 && m_cnt == 0) m_mode = 0;
    end else if (stop) begin
      if (m_mode == 1) m_mode = 2;
    end else if (start && m_mode != 1) begin
      if (m_mode == 2 || m_cnt != 0) m_mode = 1;
    end else if (tick) begin
      if (m_cnt == 0) m_mode = 0;
      else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_exp = 1;
          if (periodic) m_cnt = m_rel;
          else m_mode = 0;
        end
      end
    end
  endtask

  // One clock edge: drive, let DUT and model take the edge, queue expectation.
  task automatic step(input bit c, input bit l, input int v, input bit s,
                      input bit p, input bit per);
    exp_t e;
    clear = c; load = l; load_val = W'(v); start = s; stop = p; periodic = per;
    @(posedge clk);
    model_edge();
    e.cnt = m_cnt; e.busy = (m_mode != 0); e.exp = m_exp;
    q.push_back(e);
    #1;
    if (expired_o) exp_seen++;
  endtask

  task automatic idle(input int n, input bit per);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, per);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("count", int'(count_o), e.cnt);
      check("busy", int'(busy_o), int'(e.busy));
      check("expired", int'(expired_o), int'(e.exp));
    end
  end

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_count", int'(count_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_expired", int'(expired_o), 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk) #1;

    // Async reset mid-RUN with count 7, then start is ignored
    step(0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    check("pre_rst_count", int'(count_o), 7);
    rstn = 1'b0;
    #1;
    check("async_rst_count", int'(count_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_expired", int'(expired_o), 0);
    q.delete();
    model_reset();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk) #1;
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);

    // One-shot load 3: expiry 3 cycles after first RUN cycle
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
      if (expired_o) break;
    end
    check("oneshot_latency", n, 3);
    idle(2, 0);

    // Periodic load 4: five pulses in 20 cycles
    step(0, 1, 4, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    exp_seen = 0;
    idle(20, 1);
    check("periodic4_pulses", exp_seen, 5);
    // Reload 1: pulse every cycle
    step(0, 1, 1, 0, 0, 1);
    exp_seen = 0;
    idle(10, 1);
    check("periodic1_pulses", exp_seen, 10);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);

    // Pause: expiry 6 cycles later than the uninterrupted 5
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    n = 0;
    step(0, 0, 0, 0, 0, 0); n++;
    step(0, 0, 0, 0, 1, 0); n++;
    for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0, 0, 0); n++; end
    step(0, 0, 0, 1, 0, 0); n++;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
      if (expired_o) break;
    end
    check("pause_latency", n, 11);

    // Priority: clear beats load; load 0 in RUN; start at count 0
    step(0, 1, 6, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 6, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);

`ifdef DOWN_TIMER_PRESCALER_EN
    // Prescaler 2, load 2: expiry 6 cycles after first RUN cycle
    presc = 8'd2;
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
      if (expired_o) break;
    end
    check("presc_latency", n, 6);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      bit c, l, s, p;
      r = int'($urandom_range(0, 99));
      c = (r < 3);
      l = (r >= 3 && r < 13);
      s = (r >= 13 && r < 33);
      p = (r >= 33 && r < 41);
      if ($urandom_range(0, 29) == 0) periodic = ~periodic;
`ifdef DOWN_TIMER_PRESCALER_EN
      if ($urandom_range(0, 19) == 0) presc = 8'($urandom_range(0, 2));
`endif
      step(c, l, int'($urandom_range(0, 6)), s, p, periodic);
    end

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
